// File: rtl/rdma_hdr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rdma_hdr_pkg : RDMA header layout shared by the RX parser and TX inserter.
// Revision 1.0
// ----------------------------------------------------------------------------
package rdma_hdr_pkg;

  localparam int          HDR_BEATS  = 7;
  localparam logic [23:0] HDR_MARKER = 24'hABABAB;

  localparam int OPCODE_W = 8;
  localparam int PSN_W    = 24;
  localparam int QP_W     = 24;
  localparam int ADDR_W   = 32;
  localparam int FRAG_W   = 16;
  localparam int LEN_W    = 32;
  localparam int PKEY_W   = 16;
  localparam int SL_W     = 8;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_HDR_OUT = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_t;

  // The last header beat carries the marker in its upper three bytes.
  function automatic logic marker_ok(input logic [31:0] beat);
    return beat[31:8] == HDR_MARKER;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter16 : 16-bit event counter that sticks at 16'hFFFF.
// Revision 1.0
// ----------------------------------------------------------------------------
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_header_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rx_header_parser : strips the RDMA header off an AXI-Stream packet, presents
// the decoded fields and forwards the payload with zero latency.
// Revision 1.0
// ----------------------------------------------------------------------------
module rx_header_parser
  import rdma_hdr_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_AXIS_TKEEP_WIDTH = 4,
  parameter int HEADER_BEATS       = HDR_BEATS
) (
  input  logic                          aclk,
  input  logic                          areset,

  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,

  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,

  output logic [OPCODE_W-1:0]           hdr_opcode,
  output logic [PSN_W-1:0]              hdr_psn,
  output logic [QP_W-1:0]               hdr_dest_qp,
  output logic [ADDR_W-1:0]             hdr_remote_addr,
  output logic [FRAG_W-1:0]             hdr_fragment_offset,
  output logic [LEN_W-1:0]              hdr_length,
  output logic [PKEY_W-1:0]             hdr_partition_key,
  output logic [SL_W-1:0]               hdr_service_level,
  output logic                          hdr_valid,
  input  logic                          hdr_ready,

  output logic                          rx_busy,
  output logic                          rx_done,
  output logic                          hdr_err,
  output logic                          len_err,
  output logic [15:0]                   pkt_count,
  output logic [15:0]                   err_count
);

  localparam logic [2:0] LAST_BEAT = 3'(HEADER_BEATS - 1);

  rx_state_t        state;
  rx_state_t        state_next;
  logic [2:0]       beat_cnt;
  logic [LEN_W-1:0] pay_cnt;
  logic             last_on_hdr;
  logic             hdr_accept;
  logic             pay_accept;
  logic             done_next;
  logic             hdr_err_next;
  logic             len_err_next;

  assign hdr_accept = (state == ST_HEADER) && s_axis_tvalid;
  assign pay_accept = (state == ST_PAYLOAD) && s_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_HEADER;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    hdr_err_next = 1'b0;
    len_err_next = 1'b0;
    case (state)
      ST_HEADER: begin
        if (s_axis_tvalid) begin
          if (beat_cnt == LAST_BEAT) begin
            if (marker_ok(s_axis_tdata[31:0])) begin
              state_next = ST_HDR_OUT;
            end else begin
              hdr_err_next = 1'b1;
              state_next   = s_axis_tlast ? ST_HEADER : ST_DROP;
            end
          end else if (s_axis_tlast) begin
            hdr_err_next = 1'b1;
          end
        end
      end
      ST_HDR_OUT: begin
        if (hdr_ready) begin
          if (last_on_hdr) begin
            done_next    = (hdr_length == '0);
            len_err_next = (hdr_length != '0);
            state_next   = ST_HEADER;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pay_accept && s_axis_tlast) begin
          done_next    = ((pay_cnt + 32'd1) == hdr_length);
          len_err_next = ((pay_cnt + 32'd1) != hdr_length);
          state_next   = ST_HEADER;
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_next = ST_HEADER;
        end
      end
      default: state_next = ST_HEADER;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    hdr_valid     = 1'b0;
    case (state)
      ST_HDR_OUT: begin
        s_axis_tready = 1'b0;
        hdr_valid     = 1'b1;
      end
      ST_PAYLOAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tlast  = s_axis_tlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt            <= 3'd0;
      pay_cnt             <= '0;
      last_on_hdr         <= 1'b0;
      hdr_opcode          <= '0;
      hdr_psn             <= '0;
      hdr_dest_qp         <= '0;
      hdr_remote_addr     <= '0;
      hdr_fragment_offset <= '0;
      hdr_length          <= '0;
      hdr_partition_key   <= '0;
      hdr_service_level   <= '0;
      rx_done             <= 1'b0;
      hdr_err             <= 1'b0;
      len_err             <= 1'b0;
    end else begin
      rx_done <= done_next;
      hdr_err <= hdr_err_next;
      len_err <= len_err_next;

      if (hdr_accept) begin
        // A tlast inside the header aborts it; the next beat restarts at 0.
        if ((beat_cnt == LAST_BEAT) || s_axis_tlast) begin
          beat_cnt <= 3'd0;
        end else begin
          beat_cnt <= beat_cnt + 3'd1;
        end
        case (beat_cnt)
          3'd0: begin
            hdr_psn    <= s_axis_tdata[31:8];
            hdr_opcode <= s_axis_tdata[7:0];
          end
          3'd1: hdr_dest_qp         <= s_axis_tdata[23:0];
          3'd2: hdr_remote_addr     <= s_axis_tdata[31:0];
          3'd3: hdr_fragment_offset <= s_axis_tdata[15:0];
          3'd4: hdr_length          <= s_axis_tdata[31:0];
          3'd5: hdr_partition_key   <= s_axis_tdata[15:0];
          default: begin
            hdr_service_level <= s_axis_tdata[7:0];
            last_on_hdr       <= s_axis_tlast;
          end
        endcase
      end

      if (state == ST_HDR_OUT) begin
        pay_cnt <= '0;
      end else if (pay_accept) begin
        pay_cnt <= pay_cnt + 32'd1;
      end
    end
  end

  assign rx_busy = !((state == ST_HEADER) && (beat_cnt == 3'd0));

  sat_counter16 u_pkt_count (
    .clk   (aclk),
    .rst   (areset),
    .inc   (done_next),
    .count (pkt_count)
  );

  sat_counter16 u_err_count (
    .clk   (aclk),
    .rst   (areset),
    .inc   (hdr_err_next | len_err_next),
    .count (err_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_rx_header_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rx_header_parser : randomized packet-level bench for rx_header_parser.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_rx_header_parser;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] psn;
    logic [23:0] dest_qp;
    logic [31:0] raddr;
    logic [15:0] frag;
    logic [31:0] len;
    logic [15:0] pkey;
    logic [7:0]  sl;
  } hdr_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [7:0]  hdr_opcode;
  logic [23:0] hdr_psn;
  logic [23:0] hdr_dest_qp;
  logic [31:0] hdr_remote_addr;
  logic [15:0] hdr_fragment_offset;
  logic [31:0] hdr_length;
  logic [15:0] hdr_partition_key;
  logic [7:0]  hdr_service_level;
  logic        hdr_valid;
  logic        hdr_ready;
  logic        rx_busy;
  logic        rx_done;
  logic        hdr_err;
  logic        len_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  rx_header_parser dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tkeep        (s_axis_tkeep),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tready       (s_axis_tready),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tkeep        (m_axis_tkeep),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tready       (m_axis_tready),
    .hdr_opcode          (hdr_opcode),
    .hdr_psn             (hdr_psn),
    .hdr_dest_qp         (hdr_dest_qp),
    .hdr_remote_addr     (hdr_remote_addr),
    .hdr_fragment_offset (hdr_fragment_offset),
    .hdr_length          (hdr_length),
    .hdr_partition_key   (hdr_partition_key),
    .hdr_service_level   (hdr_service_level),
    .hdr_valid           (hdr_valid),
    .hdr_ready           (hdr_ready),
    .rx_busy             (rx_busy),
    .rx_done             (rx_done),
    .hdr_err             (hdr_err),
    .len_err             (len_err),
    .pkt_count           (pkt_count),
    .err_count           (err_count)
  );

  always #5 aclk = ~aclk;

  hdr_t dut_hdr;
  assign dut_hdr = {hdr_opcode, hdr_psn, hdr_dest_qp, hdr_remote_addr,
                    hdr_fragment_offset, hdr_length, hdr_partition_key,
                    hdr_service_level};

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  bit rand_tready = 1'b0;

  // observed traffic, collected away from the active edge
  logic [36:0] out_q[$];
  hdr_t        hdr_q[$];
  int          n_done, n_herr, n_lerr;
  bit          excl_bad;

  initial forever begin
    @(negedge aclk);
    if (!areset) begin
      if (m_axis_tvalid && m_axis_tready)
        out_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
      if (hdr_valid && hdr_ready) hdr_q.push_back(dut_hdr);
      if (rx_done) n_done++;
      if (hdr_err) n_herr++;
      if (len_err) n_lerr++;
      if ((int'(rx_done) + int'(hdr_err) + int'(len_err)) > 1) excl_bad = 1'b1;
    end
  end

  initial forever begin
    @(posedge aclk);
    #2;
    if (rand_tready) m_axis_tready = 1'($urandom_range(0, 1));
  end

  function automatic logic [31:0] hdr_word(input hdr_t h, input int i);
    case (i)
      0:       return {h.psn, h.opcode};
      1:       return {8'h00, h.dest_qp};
      2:       return h.raddr;
      3:       return {16'h0000, h.frag};
      4:       return h.len;
      5:       return {16'h0000, h.pkey};
      default: return {24'hABABAB, h.sl};
    endcase
  endfunction

  function automatic hdr_t rand_hdr(input int len);
    hdr_t h;
    h.opcode  = 8'($urandom);
    h.psn     = 24'($urandom);
    h.dest_qp = 24'($urandom);
    h.raddr   = $urandom;
    h.frag    = 16'($urandom);
    h.len     = 32'(len);
    h.pkey    = 16'($urandom);
    h.sl      = 8'($urandom);
    return h;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int  waited = 0;
    bit  acc    = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!acc) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      waited++;
      if (!acc && waited > 200) begin
        checks++;
        errors++;
        $display("FAIL send_beat_timeout: s_axis_tready=%0b after %0d cycles, required 1", s_axis_tready, waited);
        acc = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
  endtask

  // Sends one packet and checks the outcome against the packet-level rules:
  // a broken header gives hdr_err and nothing else; a good header is always
  // presented and its payload forwarded in full, ending in rx_done when the
  // beat count equals the length field and len_err otherwise.
  task automatic run_packet(input string name, input hdr_t h, input int n_pay,
                            input bit bad, input int early, input int stall);
    logic [36:0] exp_q[$];
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          e_done = 0, e_herr = 0, e_lerr = 0, e_hdr = 0, beat_bad = 0;

    if (early < 6 || bad) e_herr = 1;
    else begin
      e_hdr = 1;
      if (n_pay == int'(h.len)) e_done = 1; else e_lerr = 1;
    end

    out_q.delete(); hdr_q.delete();
    n_done = 0; n_herr = 0; n_lerr = 0; excl_bad = 1'b0;
    hdr_ready = (stall == 0);

    for (int i = 0; i < 7; i++) begin
      d = hdr_word(h, i);
      if (i == 6 && bad) d[31:8] = 24'h123456;
      l = (i == early) || (i == 6 && n_pay == 0);
      send_beat(d, 4'hF, l);
      if (i == early) break;
    end

    if (stall > 0 && e_hdr == 1) begin
      for (int c = 0; c < stall; c++) begin
        checks++;
        if (s_axis_tready !== 1'b0 || hdr_valid !== 1'b1 || dut_hdr !== h ||
            rx_busy !== 1'b1 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0) begin
          errors++;
          $display("FAIL %s_stall cyc%0d: tready=%0b hvalid=%0b busy=%0b mvalid=%0b fields=%h, required 0/1/1/0 fields=%h",
                   name, c, s_axis_tready, hdr_valid, rx_busy, m_axis_tvalid, dut_hdr, h);
        end
        @(posedge aclk);
        #1;
      end
      hdr_ready = 1'b1;
    end

    if (early >= 6) begin
      for (int j = 0; j < n_pay; j++) begin
        d = $urandom;
        k = 4'($urandom_range(1, 15));
        l = (j == n_pay - 1);
        if (e_hdr == 1) exp_q.push_back({l, k, d});
        send_beat(d, k, l);
      end
    end

    repeat (5) @(posedge aclk);
    #1;
    exp_pkt += e_done;
    exp_err += e_herr + e_lerr;

    checks++;
    if (n_done != e_done || n_herr != e_herr || n_lerr != e_lerr) begin
      errors++;
      $display("FAIL %s_pulses: done/herr/lerr=%0d/%0d/%0d, required %0d/%0d/%0d",
               name, n_done, n_herr, n_lerr, e_done, e_herr, e_lerr);
    end
    checks++;
    if (hdr_q.size() != e_hdr) begin
      errors++;
      $display("FAIL %s_hdr_count: got %0d header handshakes, required %0d", name, hdr_q.size(), e_hdr);
    end else if (e_hdr == 1) begin
      checks++;
      if (hdr_q[0] !== h) begin
        errors++;
        $display("FAIL %s_hdr_fields: got %h, required %h", name, hdr_q[0], h);
      end
    end
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_out_count: got %0d beats, required %0d", name, out_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) beat_bad++;
      checks++;
      if (beat_bad != 0) begin
        errors++;
        $display("FAIL %s_out_data: %0d beats differ, first got %h required %h",
                 name, beat_bad, out_q[0], exp_q[0]);
      end
    end
    checks++;
    if (excl_bad) begin
      errors++;
      $display("FAIL %s_exclusive: overlapping pulses seen=1, required 0", name);
    end
    checks++;
    if (pkt_count !== 16'(exp_pkt) || err_count !== 16'(exp_err)) begin
      errors++;
      $display("FAIL %s_counters: pkt=%0d err=%0d, required pkt=%0d err=%0d",
               name, pkt_count, err_count, exp_pkt, exp_err);
    end
    checks++;
    if (rx_busy !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b tready=%0b, required 0/1", name, rx_busy, s_axis_tready);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || hdr_valid !== 1'b0 ||
        rx_busy !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tkeep !== 4'h0 || m_axis_tlast !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: tready=%0b mvalid=%0b hvalid=%0b busy=%0b, required 1/0/0/0",
               name, s_axis_tready, m_axis_tvalid, hdr_valid, rx_busy);
    end
    checks++;
    if (dut_hdr !== '0) begin
      errors++;
      $display("FAIL %s_fields: got %h, required 0", name, dut_hdr);
    end
    checks++;
    if (rx_done !== 1'b0 || hdr_err !== 1'b0 || len_err !== 1'b0 ||
        pkt_count !== 16'h0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL %s_status: done=%0b herr=%0b lerr=%0b pkt=%0d err=%0d, required all 0",
               name, rx_done, hdr_err, len_err, pkt_count, err_count);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_basic();
    hdr_t h = rand_hdr(4);
    h.opcode = 8'h0A;
    h.psn    = 24'h000123;
    run_packet("basic", h, 4, 1'b0, 7, 0);
  endtask

  task automatic test_bad_marker();
    hdr_t h = rand_hdr(3);
    h.sl = 8'h05;
    run_packet("bad_marker", h, 3, 1'b1, 7, 0);
    run_packet("bad_marker_last", rand_hdr(2), 0, 1'b1, 7, 0);
    run_packet("after_bad", rand_hdr(2), 2, 1'b0, 7, 0);
  endtask

  task automatic test_early_tlast();
    run_packet("early_tlast0", rand_hdr(1), 0, 1'b0, 0, 0);
    run_packet("early_tlast5", rand_hdr(1), 0, 1'b0, 5, 0);
    run_packet("after_early", rand_hdr(1), 1, 1'b0, 7, 0);
  endtask

  task automatic test_len_err();
    run_packet("short_payload", rand_hdr(4), 2, 1'b0, 7, 0);
    run_packet("long_payload", rand_hdr(2), 5, 1'b0, 7, 0);
    run_packet("hdr_only_nonzero", rand_hdr(3), 0, 1'b0, 7, 0);
  endtask

  task automatic test_hdr_stall();
    run_packet("hdr_stall", rand_hdr(3), 3, 1'b0, 7, 10);
  endtask

  task automatic test_zero_len();
    run_packet("zero_len", rand_hdr(0), 0, 1'b0, 7, 0);
  endtask

  task automatic test_random();
    int len, n, early;
    bit bad;
    rand_tready = 1'b1;
    for (int p = 0; p < 16; p++) begin
      len = $urandom_range(0, 6);
      case ($urandom_range(0, 3))
        0:       n = len + 1;
        1:       n = (len > 0) ? len - 1 : 0;
        default: n = len;
      endcase
      bad   = ($urandom_range(0, 7) == 0);
      early = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : 7;
      run_packet($sformatf("rand%0d", p), rand_hdr(len), n, bad, early,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end
    rand_tready   = 1'b0;
    @(posedge aclk);
    #3;
    m_axis_tready = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++)
      run_packet($sformatf("b2b%0d", p), rand_hdr(p + 1), p + 1, 1'b0, 7, 0);
  endtask

  task automatic test_reset_mid();
    hdr_t h = rand_hdr(4);
    for (int i = 0; i < 7; i++) send_beat(hdr_word(h, i), 4'hF, 1'b0);
    send_beat($urandom, 4'hF, 1'b0);
    send_beat($urandom, 4'hF, 1'b0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    check_reset_values("reset_mid");
    exp_pkt = 0;
    exp_err = 0;
    run_packet("after_reset", rand_hdr(2), 2, 1'b0, 7, 0);
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    hdr_ready     = 1'b1;
    test_reset();
    test_basic();
    test_bad_marker();
    test_early_tlast();
    test_len_err();
    test_hdr_stall();
    test_zero_len();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_header_parser.md
RX_HEADER_PARSER -- requirements
Module: rx_header_parser

Interface
REQ-001 SHALL have parameters: C_AXIS_TDATA_WIDTH, default 32, data width (only 32 supported); C_AXIS_TKEEP_WIDTH, default 4, keep width; HEADER_BEATS, default 7, header length in beats.
REQ-002 SHALL have ports: aclk  in  1  sole clock; areset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: s_axis_tdata/tkeep/tvalid/tlast  in  32/4/1/1; s_axis_tready  out  1  framed input stream (7-beat RDMA header, then payload).
REQ-004 SHALL have ports: m_axis_tdata/tkeep/tvalid/tlast  out  32/4/1/1; m_axis_tready  in  1  payload-only output stream.
REQ-005 SHALL have ports: hdr_opcode out 8; hdr_psn out 24; hdr_dest_qp out 24; hdr_remote_addr out 32; hdr_fragment_offset out 16; hdr_length out 32 (payload beats); hdr_partition_key out 16; hdr_service_level out 8.
REQ-006 SHALL have ports: hdr_valid  out  1  header fields valid; hdr_ready  in  1  consumer accepts the header.
REQ-007 SHALL have ports: rx_busy out 1; rx_done out 1 (pulse); hdr_err out 1 (pulse); len_err out 1 (pulse); pkt_count out 16; err_count out 16.

Function
REQ-008 SHALL decode beats as: 0={psn,opcode}; 1={8'h00,dest_qp}; 2=remote_addr; 3={16'h0000,frag_offset}; 4=length; 5={16'h0000,pkey}; 6={24'hABABAB,service_level}.
REQ-009 SHALL implement FSM states HEADER, HDR_OUT, PAYLOAD, DROP; the reset state is HEADER.
REQ-010 HEADER: s_axis_tready=1 and m_axis_tvalid=0; each accepted beat is registered into its field; a 3-bit beat counter increments per accepted beat.
REQ-011 On acceptance of beat 6: if tdata[31:8]==24'hABABAB, go to HDR_OUT; otherwise pulse hdr_err for 1 cycle and go to DROP (or to HEADER if tlast=1 on that beat).
REQ-012 An s_axis_tlast on any of header beats 0-5 SHALL pulse hdr_err, reset the beat counter and stay in HEADER.
REQ-013 HDR_OUT: hdr_valid=1, s_axis_tready=0; header fields stay stable until the cycle in which hdr_valid&&hdr_ready is true.
REQ-014 On header handshake: if beat 6 carried tlast, then with hdr_length==0 pulse rx_done, otherwise pulse len_err; in both cases go to HEADER. If beat 6 did not carry tlast, go to PAYLOAD.
REQ-015 PAYLOAD: combinational pass-through: m_axis_tdata/tkeep/tlast/tvalid = s_axis_*; s_axis_tready = m_axis_tready; zero latency.
REQ-016 A 32-bit payload counter SHALL count accepted payload beats, starting from 0 at PAYLOAD entry.
REQ-017 On accepted payload beat with tlast: if count+1==hdr_length, pulse rx_done, else pulse len_err; go to HEADER the next cycle. A payload longer than hdr_length is still forwarded in full.
REQ-018 DROP: s_axis_tready=1 and m_axis_tvalid=0; discard beats until tlast is accepted, then go to HEADER.
REQ-019 pkt_count SHALL increment on each rx_done; err_count SHALL increment on each hdr_err or len_err; both saturate at 16'hFFFF.
REQ-020 rx_busy SHALL be 0 only in HEADER with the beat counter at 0.
REQ-021 rx_done, hdr_err and len_err SHALL be registered single-cycle pulses and mutually exclusive.
REQ-022 Outputs not in pass-through SHALL drive m_axis_tdata/tkeep/tlast to 0.

Reset
REQ-023 When areset=1 at a clock edge: state=HEADER, counters=0, all header fields=0, hdr_valid=0, pulses=0, pkt_count=err_count=0, s_axis_tready=1, m_axis_tvalid=0.
REQ-024 A reset during any state SHALL abandon the current packet with no pulse; the next beat received is treated as header beat 0.

Structure
REQ-025 Header beat count, the ABABAB marker and field widths SHALL live in a shared package rdma_hdr_pkg, common with the TX header inserter.
REQ-026 The block SHALL be a single module; the saturating counters MAY use one sub-module, sat_counter16.

Verification
REQ-027 Header opcode 0x0A, psn 0x000123, length 4, 4 payload beats with tlast on the last -> hdr_valid with the matching fields; 4 beats out on m_axis; rx_done once; pkt_count=1.
REQ-028 Beat 6 = 0x12345605 -> hdr_err pulse; m_axis_tvalid stays 0 until tlast; err_count=1; the next good packet parses correctly.
REQ-029 Header length 4, tlast on payload beat 2 -> len_err pulse, 2 beats forwarded, return to HEADER.
REQ-030 hdr_ready held low for 10 cycles -> s_axis_tready=0 and fields stable; payload flows after hdr_ready=1.
REQ-031 Length 0 with tlast on beat 6 -> rx_done after the header handshake, no m_axis beats; m_axis_tready toggled randomly during payload -> no beat lost or duplicated.
REQ-032 areset asserted mid-payload -> all outputs at reset values the next cycle; a fresh packet then parses correctly.
